// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU and its neighbours (the
// accumulator picks up ALU_W from here too).
//   ALU_W     : datapath width of operands and result
//   MUL_ITERS : shift-add iterations for MUL
//   op_e      : 3-bit operation codes (110/111 are reserved)
//   state_e   : control FSM states
package alu_pkg;
    localparam int ALU_W     = 12;
    localparam int MUL_ITERS = 12;
    localparam int CNT_W     = $clog2(MUL_ITERS + 1);

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_INC  = 3'b100,
        OP_DEC  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2
    } state_e;
endpackage

// File: rtl/alu_seq_if.sv
// Control/data bundle between the control unit (master) and alu_seq (slave).
//   start/op      : launch request and opcode
//   in1/in2       : operand A (accumulator) and operand B (data bus, N wide)
//   alu_out       : registered result
//   done/busy     : completion pulse and multi-cycle busy indicator
//   z_flag/c_flag : zero and carry/borrow/overflow flags
interface alu_seq_if #(
    parameter int N = 16
);
    import alu_pkg::*;

    logic             start;
    logic [2:0]       op;
    logic [ALU_W-1:0] in1;
    logic [N-1:0]     in2;
    logic [ALU_W-1:0] alu_out;
    logic             done;
    logic             busy;
    logic             z_flag;
    logic             c_flag;

    modport master (
        output start, op, in1, in2,
        input  alu_out, done, busy, z_flag, c_flag
    );

    modport slave (
        input  start, op, in1, in2,
        output alu_out, done, busy, z_flag, c_flag
    );
endinterface

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier core.
//   load    : latch operands, clear product and iteration count
//   step    : one iteration; adds A<<count when B[count] is set
//   last    : the current count is the final iteration
//   product : full 2*ALU_W-bit product accumulated so far
module shift_add_mul
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [ALU_W-1:0]     a,
    input  logic [ALU_W-1:0]     b,
    output logic                 last,
    output logic [2*ALU_W-1:0]   product
);
    logic [ALU_W-1:0]   a_q;
    logic [ALU_W-1:0]   b_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*ALU_W-1:0] prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            prod_q <= '0;
        end else if (load) begin
            a_q    <= a;
            b_q    <= b;
            cnt    <= '0;
            prod_q <= '0;
        end else if (step) begin
            if (b_q[cnt])
                prod_q <= prod_q + ({{ALU_W{1'b0}}, a_q} << cnt);
            cnt <= cnt + 1'b1;
        end
    end

    assign last    = (cnt == CNT_W'(MUL_ITERS - 1));
    assign product = prod_q;
endmodule

// File: rtl/alu_seq.sv
// Sequential 12-bit ALU feeding the accumulator.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_seq_if slave (start/op/in1/in2 in; alu_out/done/busy/flags out)
// Single-cycle ops complete on the accepting edge; MUL runs through the
// shift_add_mul core (IDLE -> MUL x12 -> FIN) with busy high throughout.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    state_e state, state_d;

    logic [N-1:0]       in2_full;
    logic [ALU_W-1:0]   a, b;
    logic [ALU_W:0]     sum, diff, inc, dec;
    logic [ALU_W-1:0]   res_d, out_q;
    logic               c_d, c_q, done_d, done_q;
    logic               load, step, last;
    logic [2*ALU_W-1:0] product;

    assign in2_full = bus.in2;
    assign a        = bus.in1;
    assign b        = in2_full[ALU_W-1:0];

    // Upper data-bus bits are intentionally ignored.
    wire unused_ok = &{1'b0, in2_full[N-1:ALU_W]};

    // Bit ALU_W of each 13-bit result is the carry (add) or borrow (subtract).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign inc  = {1'b0, a} + 1'b1;
    assign dec  = {1'b0, a} - 1'b1;

    shift_add_mul u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .a       (a),
        .b       (b),
        .last    (last),
        .product (product)
    );

    always_comb begin
        state_d = state;
        res_d   = out_q;
        c_d     = c_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    done_d = 1'b1;
                    case (op_e'(bus.op))
                        OP_PASS: begin res_d = b;                 c_d = 1'b0;       end
                        OP_ADD:  begin res_d = sum[ALU_W-1:0];    c_d = sum[ALU_W]; end
                        OP_SUB:  begin res_d = diff[ALU_W-1:0];   c_d = diff[ALU_W]; end
                        OP_INC:  begin res_d = inc[ALU_W-1:0];    c_d = inc[ALU_W]; end
                        OP_DEC:  begin res_d = dec[ALU_W-1:0];    c_d = dec[ALU_W]; end
                        OP_MUL: begin
                            done_d  = 1'b0;
                            load    = 1'b1;
                            state_d = S_MUL;
                        end
                        default: ; // reserved: result and carry hold, done still pulses
                    endcase
                end
            end
            S_MUL: begin
                step = 1'b1;
                if (last)
                    state_d = S_FIN;
            end
            S_FIN: begin
                res_d   = product[ALU_W-1:0];
                c_d     = |product[2*ALU_W-1:ALU_W];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            out_q  <= '0;
            c_q    <= 1'b0;
            done_q <= 1'b0;
            bus.z_flag <= 1'b1;
        end else begin
            state  <= state_d;
            out_q  <= res_d;
            c_q    <= c_d;
            done_q <= done_d;
            bus.z_flag <= (res_d == '0);
        end
    end

    assign bus.alu_out = out_q;
    assign bus.c_flag  = c_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state != S_IDLE);
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes the reference result of
// every accepted operation; the monitor pops and compares on each done.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [11:0] out;
        logic        c;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   m_out = 0;
    int   m_c   = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.N(16)) bus ();
    alu_seq #(.N(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 4096.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   p;
        case (op)
            0: begin m_out = b; m_c = 0; end
            1: begin p = a + b; m_out = p % 4096; m_c = (p >= 4096); end
            2: begin m_out = (a - b + 4096) % 4096; m_c = (a < b); end
            3: begin p = a * b; m_out = p % 4096; m_c = (p >= 4096); end
            4: begin p = a + 1; m_out = p % 4096; m_c = (p >= 4096); end
            5: begin m_out = (a + 4095) % 4096; m_c = (a == 0); end
            default: ;
        endcase
        e.out = 12'(m_out);
        e.c   = (m_c != 0);
        e.z   = (m_out == 0);
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("alu_out", int'(bus.alu_out), int'(e.out));
                chk("c_flag", int'(bus.c_flag), int'(e.c));
                chk("z_flag", int'(bus.z_flag), int'(e.z));
            end
        end
    end

    // Present inputs with start=1 at a negedge; caller lowers start later.
    task automatic drive(input int op, input int a, input int b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'(op);
        bus.in1   = 12'(a);
        bus.in2   = 16'(b) | 16'hA000; // upper bus bits must be ignored
        sb.push_back(model(op, a, b));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic single(input int op, input int a, input int b);
        drive(op, a, b);
        idle();
    endtask

    // MUL with latency/busy checks; optionally pokes an ADD start mid-flight.
    task automatic mul(input int a, input int b, input bit poke);
        int n, busy_n;
        drive(3, a, b);
        @(posedge clk); #1;            // accepting edge k
        bus.start = 1'b0;
        busy_n = bus.busy ? 1 : 0;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.busy) busy_n++;
            bus.in1 = 12'($urandom);
            bus.in2 = 16'($urandom);
            if (poke) begin
                bus.start = (n == 3 || n == 13);
                bus.op    = 3'd1;
            end
        end
        bus.start = 1'b0;
        chk("mul_latency", n, 13);
        chk("mul_busy_cycles", busy_n, 13);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.in1   = '0;
        bus.in2   = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_alu_out", int'(bus.alu_out), 0);
        chk("rst_z", int'(bus.z_flag), 1);
        chk("rst_c", int'(bus.c_flag), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);

        // Directed
        single(1, 12'hFFF, 12'h001);
        single(1, 12'h123, 12'h045);
        single(2, 12'h005, 12'h007);
        single(5, 12'h000, 0);
        single(4, 12'h7FF, 0);
        mul(12'h00C, 12'h00D, 1'b0);
        mul(12'h100, 12'h100, 1'b0);
        mul(12'h0AB, 12'h013, 1'b1);   // ADD starts during MUL are dropped

        // Back-to-back singles then reserved ops
        drive(0, 12'h0F0, 12'h321);
        drive(1, 12'h800, 12'h800);
        drive(2, 12'h050, 12'h010);
        drive(4, 12'hFFF, 0);
        drive(7, 12'h111, 12'h222);
        drive(6, 12'h333, 12'h444);
        idle();
        single(1, 12'h010, 12'h020);
        single(7, 12'h000, 12'h000);

        // Reset mid-MUL
        drive(3, 12'h0FF, 12'h0FF);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_alu_out", int'(bus.alu_out), 0);
        chk("mrst_z", int'(bus.z_flag), 1);
        chk("mrst_c", int'(bus.c_flag), 0);
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_done", int'(bus.done), 0);
        sb.delete();
        m_out = 0;
        m_c   = 0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);    // an unexpected done would be flagged here

        // Random mix
        for (int i = 0; i < 60; i++) begin
            int op, a, b;
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, 4095);
            b  = $urandom_range(0, 4095);
            if ($urandom_range(0, 3) == 0) begin
                a = a & 12'hF00 ? 12'hFFF : 0;
            end
            if (op == 3) begin
                mul(a, b, $urandom_range(0, 1) == 1);
            end else begin
                drive(op, a, b);
                if ($urandom_range(0, 1) == 1) idle();
            end
        end
        idle();

        begin
            int t;
            t = 0;
            while (sb.size() != 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("scoreboard_drained", sb.size(), 0);
        end
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential 12-bit ALU that sits directly upstream of the accumulator. It takes operand 1 from the accumulator's `alu_in` and operand 2 from the data bus, and returns the result on `alu_out`. The control unit asserts the accumulator's `alu_to_ac` in the cycle `done` is high. Single-cycle ops finish in one clock; MUL is a 12-iteration shift-add, so the control unit waits on `busy`/`done`.

## Interface
- `N`, default 16: data-bus width. Only bits [11:0] are used.
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: launch operation. Sampled on a rising edge; ignored while `busy`=1.
- `op` input, 3: operation code, sampled with `start`.
- `in1` input, 12: operand A (accumulator `alu_in`).
- `in2` input, N: operand B (data bus). Bits [11:0] are used.
- `alu_out` output, 12: registered result, feeds accumulator `alu_out`.
- `done` output, 1: one-cycle pulse; `alu_out` and flags are valid in that cycle.
- `busy` output, 1: high while MUL iterates.
- `z_flag` output, 1: registered; equals (`alu_out` == 0).
- `c_flag` output, 1: registered carry, borrow or overflow of the last op.

## Operation
- Opcodes:
  - 000 PASS: result = B.
  - 001 ADD: result = A+B.
  - 010 SUB: result = A−B.
  - 011 MUL: result = low 12 bits of A×B.
  - 100 INC: result = A+1.
  - 101 DEC: result = A−1.
  - 110, 111 reserved: `alu_out` and `c_flag` hold; `done` still pulses; `z_flag` recomputed.
- Operands are latched at the accepting `start` edge. Later changes on `in1`/`in2` have no effect.
- Width and flag rules, all modulo 2^12:
  - ADD/INC: `c_flag` = bit 12 of the 13-bit sum.
  - SUB/DEC: `c_flag` = borrow (1 when A < B, or A == 0 for DEC).
  - MUL: `c_flag` = 1 if any bit of product[23:12] is nonzero.
  - PASS: `c_flag` = 0.
- FSM states: IDLE, MUL, FIN.
  - IDLE: on `start` with a single-cycle op, compute, register results, pulse `done`, stay in IDLE. On `start` with op=MUL, latch operands, clear the 24-bit product, set iteration count = 0, go to MUL.
  - MUL: each edge, if B[count]=1 add A<<count to the product; count++. After the 12th iteration go to FIN.
  - FIN: register product[11:0] and `c_flag`, pulse `done`, return to IDLE.
- `busy` = 1 in MUL and FIN. A `start` while busy is dropped; there is no queuing.
- Reset mid-MUL: the FSM returns to IDLE immediately and the partial product is discarded.
- Reset values: `alu_out`=0, `done`=0, `busy`=0, `z_flag`=1, `c_flag`=0; FSM in IDLE; iteration count 0.

## Timing
- Single-cycle op accepted at edge k: `alu_out`, flags and `done`=1 are visible after edge k; `done` falls after edge k+1.
- Back-to-back single-cycle ops: `start` may be held on consecutive edges, giving one result per cycle.
- MUL accepted at edge k:
  - `busy` rises after edge k.
  - Iterations occur on edges k+1 … k+12.
  - FIN is entered after edge k+12.
  - Result and `done` are visible after edge k+13.
  - `busy` falls after edge k+13.
  - The earliest next accepted `start` is at edge k+14.
- `done` never stays high more than one cycle. It is never asserted without a preceding accepted `start`.

## Structure
- Shared package `alu_pkg`:
  - opcode enum (OP_PASS … OP_DEC);
  - `ALU_W` = 12;
  - `MUL_ITERS` = 12;
  - FSM state typedef.
- The accumulator uses `ALU_W` from the same package.
- One sub-module, `shift_add_mul`: holds the product register and iteration counter, with `load`/`step`/`last` interface. `alu_seq` keeps the FSM, single-cycle datapath and output registers.

## Test plan
- Reset checks:
  - Reset released → `alu_out`=0, `z_flag`=1, `c_flag`=0, `busy`=0, `done`=0.
  - Assert `rst_n`=0 mid-MUL → the same values appear immediately, with no `done`.
- ADD checks:
  - A=0xFFF, B=0x001 → `alu_out`=0x000, `c_flag`=1, `z_flag`=1, `done` one cycle after `start`.
  - A=0x123, B=0x045 → 0x168, `c_flag`=0.
- SUB/DEC checks:
  - SUB A=0x005, B=0x007 → 0xFFE, `c_flag`=1.
  - DEC A=0x000 → 0xFFF, `c_flag`=1.
  - INC A=0x7FF → 0x800, `c_flag`=0.
- MUL checks:
  - A=0x00C, B=0x00D → 0x09C, `c_flag`=0, `done` exactly 13 cycles after the accepting edge, `busy` high for 13 cycles.
  - A=0x100, B=0x100 → 0x000, `c_flag`=1.
- Handshake checks:
  - `start` with op=ADD pulsed during MUL → ignored; the MUL result is unaffected.
  - `in1`/`in2` changed during MUL → the result is unchanged.
- Pipeline and reserved op:
  - Four single-cycle ops on consecutive edges → four consecutive `done` pulses with correct results.
  - op=111 → `alu_out` holds its previous value and `done` pulses.
